// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe_if
//  Purpose  : Operand/result handshake bundle between issue stage and alu_pipe.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] src_a_i;
    logic [WIDTH-1:0] src_b_i;
    logic [3:0]       alu_control_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] alu_result_o;
    logic [2:0]       alu_flags_o;
    logic             err_o;

    modport master (
        output in_valid_i, src_a_i, src_b_i, alu_control_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_result_o, alu_flags_o, err_o
    );

    modport slave (
        input  in_valid_i, src_a_i, src_b_i, alu_control_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_result_o, alu_flags_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Handshaked, registered RV32I-style ALU with optional iterative
//             shift-add multiplier (enabled by macro ALU_PIPE_MUL_EN).
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  wire logic clk_i,
    input  wire logic rst_ni,
    alu_pipe_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_and  = 4'b0010;
    localparam logic [3:0] c_op_or   = 4'b0011;
    localparam logic [3:0] c_op_xor  = 4'b0100;
    localparam logic [3:0] c_op_slt  = 4'b0101;
    localparam logic [3:0] c_op_sltu = 4'b0110;
    localparam logic [3:0] c_op_sll  = 4'b0111;
    localparam logic [3:0] c_op_srl  = 4'b1000;
    localparam logic [3:0] c_op_sra  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_result;
    logic [2:0]         r_flags;
    logic               r_err;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_is_mul;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic               w_err;
    logic [2:0]         w_flags;
    logic [SHAMT_W-1:0] w_shamt;

    assign w_shamt    = bus.src_b_i[SHAMT_W-1:0];
    assign w_in_ready = rst_ni && ((r_state == ST_IDLE) ||
                                   ((r_state == ST_DONE) && bus.out_ready_i));
    assign w_accept   = bus.in_valid_i && w_in_ready;

    always_comb begin : p_alu
        w_res = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (bus.alu_control_i)
            c_op_add: begin
                w_res = bus.src_a_i + bus.src_b_i;
                w_ovf = (bus.src_a_i[WIDTH-1] == bus.src_b_i[WIDTH-1]) &&
                        (w_res[WIDTH-1] != bus.src_a_i[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = bus.src_a_i - bus.src_b_i;
                w_ovf = (bus.src_a_i[WIDTH-1] != bus.src_b_i[WIDTH-1]) &&
                        (w_res[WIDTH-1] != bus.src_a_i[WIDTH-1]);
            end
            c_op_and:  w_res = bus.src_a_i & bus.src_b_i;
            c_op_or:   w_res = bus.src_a_i | bus.src_b_i;
            c_op_xor:  w_res = bus.src_a_i ^ bus.src_b_i;
            c_op_slt:  w_res[0] = $signed(bus.src_a_i) < $signed(bus.src_b_i);
            c_op_sltu: w_res[0] = bus.src_a_i < bus.src_b_i;
            c_op_sll:  w_res = bus.src_a_i << w_shamt;
            c_op_srl:  w_res = bus.src_a_i >> w_shamt;
            c_op_sra:  w_res = $unsigned($signed(bus.src_a_i) >>> w_shamt);
            default:   w_err = 1'b1;
        endcase
    end

    // An illegal op leaves w_res at zero, which yields flags 3'b001 naturally.
    assign w_flags = {w_ovf, w_res[WIDTH-1], ~|w_res};

`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0] c_op_mul = 4'b1010;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   w_mul_sum;
    logic               w_mul_last;

    assign w_is_mul   = (bus.alu_control_i == c_op_mul);
    assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_last = (r_cnt == SHAMT_W'(WIDTH - 1));

    always_ff @(posedge clk_i) begin : p_mul
        if (!rst_ni) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_mcand  <= bus.src_a_i;
            r_mplier <= bus.src_b_i;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == ST_BUSY) begin
            r_acc    <= w_mul_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`else
    assign w_is_mul = 1'b0;
`endif

    always_ff @(posedge clk_i) begin : p_state
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
                end
            end
`ifdef ALU_PIPE_MUL_EN
            ST_BUSY: begin
                if (w_mul_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (bus.out_ready_i) begin
                    if (w_accept) begin
                        w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin : p_result
        if (!rst_ni) begin
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result <= w_res;
            r_flags  <= w_flags;
            r_err    <= w_err;
        end
`ifdef ALU_PIPE_MUL_EN
        else if ((r_state == ST_BUSY) && w_mul_last) begin
            r_result <= w_mul_sum;
            r_flags  <= {1'b0, w_mul_sum[WIDTH-1], ~|w_mul_sum};
            r_err    <= 1'b0;
        end
`endif
    end

    assign bus.in_ready_o   = w_in_ready;
    assign bus.out_valid_o  = (r_state == ST_DONE);
    assign bus.alu_result_o = r_result;
    assign bus.alu_flags_o  = r_flags;
    assign bus.err_o        = r_err;

endmodule
`default_nettype wire
